// File: rtl/crc_frame_checker.sv
// crc_frame_checker: streaming byte-wide CRC frame checker with an N-byte trailer.
// Optional good/bad frame counters are built only when CRC_FRAME_STATS_EN is defined.
module crc_frame_checker #(
    parameter int               CRC_W   = 16,
    parameter logic [CRC_W-1:0] POLY    = 16'h1021,
    parameter logic [CRC_W-1:0] INIT    = 16'hFFFF,
    parameter logic [CRC_W-1:0] XOR_OUT = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic        frame_done,
    output logic        crc_ok,
    output logic        crc_err,
    output logic        runt_err,
    output logic [15:0] byte_cnt,
    output logic [15:0] good_cnt,
    output logic [15:0] bad_cnt
);
    localparam int N = CRC_W / 8;

    typedef enum logic [1:0] {IDLE, RUN, CHECK} state_t;

    state_t           state_q, state_d;
    logic [CRC_W-1:0] crc_q, crc_d, dl_q, dl_d;
    logic [2:0]       fill_q, fill_d;
    logic [15:0]      cnt_q, cnt_d, bcnt_q, bcnt_d;
    logic             done_q, done_d, ok_q, ok_d, err_q, err_d, runt_q, runt_d;
    logic             accept, first, full, match, chk;

    function automatic logic [CRC_W-1:0] crc_byte(input logic [CRC_W-1:0] c, input logic [7:0] d);
        logic [CRC_W-1:0] r;
        r = c;
        r[CRC_W-1 -: 8] = r[CRC_W-1 -: 8] ^ d;
        for (int i = 0; i < 8; i++) r = r[CRC_W-1] ? (r << 1) ^ POLY : r << 1;
        return r;
    endfunction

    assign s_ready = state_q != CHECK;
    assign accept  = s_valid && s_ready;
    assign first   = accept && state_q == IDLE;
    assign full    = fill_q == 3'(N);
    assign chk     = state_q == CHECK;
    assign match   = (crc_q ^ XOR_OUT) == dl_q;

    // cnt_q counts bytes folded into the CRC, i.e. payload bytes; zero means runt
    always_comb begin
        state_d = chk ? IDLE : accept ? (s_last ? CHECK : RUN) : state_q;
        crc_d   = crc_q;
        dl_d    = dl_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        if (first) begin
            crc_d  = INIT;
            dl_d   = CRC_W'(s_data);
            fill_d = 3'd1;
            cnt_d  = 16'd0;
        end else if (accept) begin
            dl_d = (dl_q << 8) | CRC_W'(s_data);
            if (full) begin
                crc_d = crc_byte(crc_q, dl_q[CRC_W-1 -: 8]);
                cnt_d = cnt_q == 16'hFFFF ? cnt_q : cnt_q + 16'd1;
            end else begin
                fill_d = fill_q + 3'd1;
            end
        end
        done_d = chk;
        runt_d = chk ? cnt_q == 16'd0 : runt_q;
        ok_d   = chk ? cnt_q != 16'd0 && match : ok_q;
        err_d  = chk ? cnt_q != 16'd0 && !match : err_q;
        bcnt_d = chk ? cnt_q : bcnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            crc_q   <= INIT;
            dl_q    <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            runt_q  <= 1'b0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            dl_q    <= dl_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            runt_q  <= runt_d;
            bcnt_q  <= bcnt_d;
        end
    end

    assign frame_done = done_q;
    assign crc_ok     = ok_q;
    assign crc_err    = err_q;
    assign runt_err   = runt_q;
    assign byte_cnt   = bcnt_q;

`ifdef CRC_FRAME_STATS_EN
    logic [15:0] good_q, good_d, bad_q, bad_d;

    // counters change on the same edge that raises frame_done
    always_comb begin
        good_d = (chk && ok_d && good_q != 16'hFFFF) ? good_q + 16'd1 : good_q;
        bad_d  = (chk && !ok_d && bad_q != 16'hFFFF) ? bad_q + 16'd1 : bad_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            good_q <= '0;
            bad_q  <= '0;
        end else begin
            good_q <= good_d;
            bad_q  <= bad_d;
        end
    end

    assign good_cnt = good_q;
    assign bad_cnt  = bad_q;
`else
    assign good_cnt = 16'd0;
    assign bad_cnt  = 16'd0;
`endif
endmodule

// File: doc/crc_frame_checker.md
CRC_FRAME_CHECKER -- requirements
Module: crc_frame_checker

Interface
REQ-001 Parameters SHALL be:
- CRC_W, 16, CRC width in bits; legal values 8, 16, 24, 32.
- POLY, 16'h1021, generator polynomial, normal (non-reflected) form, CRC_W bits.
- INIT, 16'hFFFF, CRC register value at frame start.
- XOR_OUT, 16'h0000, value XORed into the final CRC before comparison.

REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- s_data  in  8  frame byte.
- s_valid  in  1  s_data is valid.
- s_last  in  1  current byte is the final byte of the frame.
- s_ready  out  1  checker accepts a byte this cycle.
- frame_done  out  1  one-cycle pulse: a frame result is valid.
- crc_ok  out  1  last frame CRC matched; held until the next frame_done.
- crc_err  out  1  last frame CRC mismatched; held until the next frame_done.
- runt_err  out  1  last frame was too short to carry a CRC; held until the next frame_done.
- byte_cnt  out  16  payload byte count of the last frame, saturating at 16'hFFFF.
- good_cnt  out  16  count of good frames (see Configuration).
- bad_cnt  out  16  count of bad frames (see Configuration).

REQ-003 The block SHALL use reset reset, asynchronous, active-high; clock clk.

Function
REQ-004 A byte SHALL be accepted on a rising clk edge where s_valid and s_ready are both 1; s_data and s_last SHALL be ignored otherwise.
REQ-005 A frame SHALL consist of payload bytes followed by N = CRC_W/8 CRC bytes, most significant CRC byte first.
REQ-006 The FSM states SHALL be IDLE, RUN and CHECK:
- IDLE goes to RUN on acceptance without s_last.
- IDLE or RUN goes to CHECK on acceptance with s_last.
- CHECK goes to IDLE unconditionally after 1 cycle.
REQ-007 s_ready SHALL be 0 in CHECK and 1 in IDLE and RUN.
REQ-008 Accepted bytes SHALL enter an N-byte delay line; a byte leaving the full delay line SHALL be folded into the CRC register.
REQ-009 The CRC update SHALL be MSB-first and bit-serial-equivalent over 8 bits: XOR the byte into the top 8 bits, then 8 iterations of shift-left with conditional XOR of POLY when the bit shifted out is 1.
REQ-010 When the first byte of a frame is accepted, the CRC register SHALL load INIT, the delay line SHALL clear, and the fill count SHALL reset.
REQ-011 In CHECK, the block SHALL compare (CRC register XOR XOR_OUT) with the delay-line contents, oldest byte in the MSB position.
REQ-012 frame_done SHALL pulse for exactly 1 cycle, on the cycle after CHECK, i.e. 2 cycles after the s_last byte is accepted.
REQ-013 crc_ok, crc_err, runt_err and byte_cnt SHALL update in the same cycle as frame_done.
REQ-014 At most one of crc_ok, crc_err and runt_err SHALL be 1 at any time.
REQ-015 A frame of total length at most N bytes SHALL set runt_err=1, crc_ok=0, crc_err=0 and byte_cnt=0.
REQ-016 byte_cnt SHALL equal total accepted bytes minus N, saturating at 16'hFFFF; the CRC computation SHALL continue past saturation.
REQ-017 A single-byte frame (s_last on the first byte) SHALL go directly from IDLE to CHECK.
REQ-018 Back-to-back frames SHALL be supported: a new frame MAY be accepted in the cycle the block returns to IDLE (the frame_done cycle).

Reset
REQ-019 Reset SHALL force state IDLE, the CRC register to INIT, the delay line and fill count to 0, and all outputs except s_ready to 0.
REQ-020 s_ready SHALL be 1 during reset.
REQ-021 Reset asserted mid-frame SHALL discard the frame with no frame_done; the next accepted byte SHALL start a new frame.

Configuration
REQ-022 With macro CRC_FRAME_STATS_EN defined, the counters SHALL behave as follows:
- good_cnt increments on each frame_done with crc_ok=1.
- bad_cnt increments on each frame_done with crc_err=1 or runt_err=1.
- Both counters saturate at 16'hFFFF and reset to 0.
REQ-023 Without CRC_FRAME_STATS_EN, good_cnt and bad_cnt SHALL be constant 0 and no counter flops SHALL be synthesised.

Verification
REQ-024 Default parameters, frame 31 32 33 34 35 36 37 38 39 29 B1 -> frame_done 2 cycles after the last byte, crc_ok=1, byte_cnt=9.
REQ-025 Same frame with the last byte B0 -> crc_err=1, crc_ok=0; with stats enabled, bad_cnt goes 0 to 1.
REQ-026 CRC_W=8, POLY=8'h07, INIT=0, XOR_OUT=0, frame 31..39 F4 -> crc_ok=1, byte_cnt=9.
REQ-027 Default parameters, 2-byte frame AA BB -> runt_err=1, byte_cnt=0; a 3-byte frame whose CRC is correct -> crc_ok=1, byte_cnt=1.
REQ-028 Two good frames back-to-back with s_valid held at 1 -> s_ready=0 only in each CHECK cycle, two frame_done pulses, good_cnt=2.
REQ-029 Reset pulsed after byte 5 of a good frame, then the full good frame resent -> exactly one frame_done, crc_ok=1.
